// File: rtl/nand_bus_sequencer.sv
// NAND flash bus-cycle sequencer: turns CMD/ADDR/WRITE/READ/WAIT_RB/CE_OFF micro-ops
// into registered ale/cle/nce/nwe/nre/data pin activity with cycle-count timing.
module nand_bus_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned T_WP   = 2,
  parameter int unsigned T_WH   = 2,
  parameter int unsigned T_RP   = 2,
  parameter int unsigned T_REH  = 2,
  parameter int unsigned T_WB   = 8,
  parameter int unsigned TO_W   = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] op_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              timeout,
  input  logic              wp_enable,
  output logic              nand_ale,
  output logic              nand_cle,
  output logic              nand_nce,
  output logic              nand_nre,
  output logic              nand_nwe,
  output logic              nand_nwp,
  output logic [DATA_W-1:0] nand_data_out,
  output logic              nand_data_oe,
  input  logic [DATA_W-1:0] nand_data_in,
  input  logic              nand_rnb
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T_MAX = max2(max2(max2(T_WP, T_WH), max2(T_RP, T_REH)), T_WB);
  localparam int unsigned CW    = $clog2(T_MAX) + 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE_LO, STROBE_HI, WB_WAIT, RB_POLL, CE_REL
  } state_t;

  typedef enum logic [2:0] {
    OP_CMD     = 3'd0,
    OP_ADDR    = 3'd1,
    OP_WRITE   = 3'd2,
    OP_READ    = 3'd3,
    OP_WAIT_RB = 3'd4,
    OP_CE_OFF  = 3'd5,
    OP_NOP6    = 3'd6,
    OP_NOP7    = 3'd7
  } op_t;

  state_t            state, state_nx;
  op_t               op_q, op_nx, op_in;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [TO_W-1:0]   to_cnt, to_cnt_nx, to_inc;
  logic              rnb_s1, rnb_s2;

  logic              cle_nx, ale_nx, nce_nx, nre_nx, nwe_nx, oe_nx;
  logic [DATA_W-1:0] data_out_nx, rd_data_nx;
  logic              rd_valid_nx, timeout_nx;

  assign op_in    = op_t'(op_code);
  assign op_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign to_inc   = to_cnt + TO_W'(1);

  always_comb begin
    state_nx    = state;
    op_nx       = op_q;
    cnt_nx      = cnt;
    to_cnt_nx   = to_cnt;
    cle_nx      = nand_cle;
    ale_nx      = nand_ale;
    nce_nx      = nand_nce;
    nre_nx      = nand_nre;
    nwe_nx      = nand_nwe;
    oe_nx       = nand_data_oe;
    data_out_nx = nand_data_out;
    rd_valid_nx = 1'b0;
    rd_data_nx  = rd_data;
    timeout_nx  = timeout;

    case (state)
      IDLE: begin
        if (op_valid) begin
          op_nx      = op_in;
          timeout_nx = 1'b0;
          case (op_in)
            OP_CMD, OP_ADDR, OP_WRITE: begin
              state_nx    = SETUP;
              nce_nx      = 1'b0;
              oe_nx       = 1'b1;
              cle_nx      = (op_in == OP_CMD);
              ale_nx      = (op_in == OP_ADDR);
              data_out_nx = (op_in == OP_WRITE) ? op_data : DATA_W'(op_data[7:0]);
            end
            OP_READ: begin
              state_nx = SETUP;
              nce_nx   = 1'b0;
              oe_nx    = 1'b0;
            end
            OP_WAIT_RB: begin
              state_nx = WB_WAIT;
              nce_nx   = 1'b0;
              cnt_nx   = CW'(T_WB - 1);
            end
            OP_CE_OFF: begin
              state_nx = CE_REL;
              nce_nx   = 1'b1;
            end
            default: state_nx = CE_REL;
          endcase
        end
      end

      SETUP: begin
        state_nx = STROBE_LO;
        if (op_q == OP_READ) begin
          nre_nx = 1'b0;
          cnt_nx = CW'(T_RP - 1);
        end else begin
          nwe_nx = 1'b0;
          cnt_nx = CW'(T_WP - 1);
        end
      end

      // Read data is captured on the edge that ends the last nRE-low cycle.
      STROBE_LO: begin
        if (cnt == '0) begin
          state_nx = STROBE_HI;
          if (op_q == OP_READ) begin
            nre_nx      = 1'b1;
            rd_valid_nx = 1'b1;
            rd_data_nx  = nand_data_in;
            cnt_nx      = CW'(T_REH - 1);
          end else begin
            nwe_nx = 1'b1;
            cnt_nx = CW'(T_WH - 1);
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end

      STROBE_HI: begin
        if (cnt == '0) begin
          state_nx    = IDLE;
          cle_nx      = 1'b0;
          ale_nx      = 1'b0;
          oe_nx       = 1'b0;
          data_out_nx = '0;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end

      WB_WAIT: begin
        if (cnt == '0) begin
          state_nx  = RB_POLL;
          to_cnt_nx = '0;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end

      RB_POLL: begin
        if (rnb_s2) begin
          state_nx = IDLE;
        end else begin
          to_cnt_nx = to_inc;
          if (to_inc == '1) begin
            timeout_nx = 1'b1;
            state_nx   = IDLE;
          end
        end
      end

      CE_REL:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      op_q          <= OP_NOP7;
      cnt           <= '0;
      to_cnt        <= '0;
      rnb_s1        <= 1'b0;
      rnb_s2        <= 1'b0;
      nand_cle      <= 1'b0;
      nand_ale      <= 1'b0;
      nand_nce      <= 1'b1;
      nand_nre      <= 1'b1;
      nand_nwe      <= 1'b1;
      nand_nwp      <= 1'b0;
      nand_data_oe  <= 1'b0;
      nand_data_out <= '0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      timeout       <= 1'b0;
    end else begin
      state         <= state_nx;
      op_q          <= op_nx;
      cnt           <= cnt_nx;
      to_cnt        <= to_cnt_nx;
      rnb_s1        <= nand_rnb;
      rnb_s2        <= rnb_s1;
      nand_cle      <= cle_nx;
      nand_ale      <= ale_nx;
      nand_nce      <= nce_nx;
      nand_nre      <= nre_nx;
      nand_nwe      <= nwe_nx;
      nand_nwp      <= ~wp_enable;
      nand_data_oe  <= oe_nx;
      nand_data_out <= data_out_nx;
      rd_valid      <= rd_valid_nx;
      rd_data       <= rd_data_nx;
      timeout       <= timeout_nx;
    end
  end

endmodule

// File: doc/nand_bus_sequencer.md
Name: nand_bus_sequencer

Overview:
- Sequences raw NAND flash bus cycles (command latch, address latch, data write, data read, ready/busy wait) from a micro-op stream, with programmable cycle-count timing.
- Sits between the NAND command engine inside the nand_avalon peripheral and the exported conduit pins (ale, cle, data, nce, nre, nwe, nwp, rnb).
- Tri-state resolution of the data bus is done at the conduit boundary; this block exposes separate out/oe/in.

Parameters:
- DATA_W, 16, NAND data bus width.
- T_WP, 2, nWE low cycles (must be >=1).
- T_WH, 2, nWE high-hold cycles after rising edge (must be >=1).
- T_RP, 2, nRE low cycles (must be >=1).
- T_REH, 2, nRE high-hold cycles (must be >=1).
- T_WB, 8, cycles from the last nWE rise before rnb is sampled.
- TO_W, 24, width of the ready/busy timeout counter; timeout fires at 2^TO_W-1 polling cycles.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- op_valid  in  1  micro-op request.
- op_ready  out  1  sequencer can accept an op this cycle.
- op_code  in  3  0=CMD, 1=ADDR, 2=WRITE, 3=READ, 4=WAIT_RB, 5=CE_OFF, 6/7=NOP.
- op_data  in  DATA_W  command, address byte or write word.
- rd_valid  out  1  one-cycle pulse: rd_data is valid.
- rd_data  out  DATA_W  captured read word.
- busy  out  1  high whenever the FSM is not in IDLE.
- timeout  out  1  sticky flag: WAIT_RB expired; cleared on the next op accept.
- wp_enable  in  1  1 = write-protect the device.
- nand_ale, nand_cle  out  1  address / command latch enable.
- nand_nce, nand_nre, nand_nwe, nand_nwp  out  1  active-low controls.
- nand_data_out  out  DATA_W  bus drive value.
- nand_data_oe  out  1  bus drive enable.
- nand_data_in  in  DATA_W  bus sample.
- nand_rnb  in  1  device ready(1)/busy(0); asynchronous input.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-op):
  - nce=1, nre=1, nwe=1, cle=0, ale=0, oe=0, data_out=0, nwp=0.
  - op_ready=1, rd_valid=0, rd_data=0, busy=0, timeout=0.
  - FSM to IDLE; rnb synchronizer cleared to 0.
- Handshake:
  - An op is accepted on a clock edge where op_valid and op_ready are both high.
  - op_ready is high only in IDLE.
  - op_code/op_data are registered at accept and need not stay stable afterwards.
- nand_nwp is registered ~wp_enable, updated every cycle independent of the FSM.
- Chip enable: any op other than CE_OFF/NOP drives nce=0 in the cycle after accept. nce stays low across ops until CE_OFF.
- FSM states: IDLE, SETUP, STROBE_LO, STROBE_HI, WB_WAIT, RB_POLL, CE_REL.
- CMD/ADDR/WRITE:
  - SETUP (1 cycle): CMD sets cle=1, ADDR sets ale=1; oe=1.
  - data_out = op_data for WRITE; for CMD/ADDR it is {zeros, op_data[7:0]}.
  - STROBE_LO: nwe=0 for T_WP cycles.
  - STROBE_HI: nwe=1 for T_WH cycles. cle/ale/oe/data are held through STROBE_HI, then cleared on return to IDLE.
  - op_ready returns 1+T_WP+T_WH cycles after accept.
- READ:
  - SETUP (1 cycle): oe=0.
  - STROBE_LO: nre=0 for T_RP cycles. nand_data_in is captured into rd_data on the clock edge that ends the final low cycle. rd_valid pulses high for the cycle after that edge, coincident with nre returning to 1.
  - STROBE_HI: T_REH cycles, then IDLE.
- WAIT_RB:
  - WB_WAIT: T_WB cycles.
  - RB_POLL: sample rnb through a 2-flop synchronizer. Return to IDLE on the first cycle synced rnb=1.
  - The counter increments each poll cycle. When it reaches all-ones: timeout=1, return to IDLE.
- CE_OFF: CE_REL (1 cycle) with nce=1, then IDLE. NOP: 1 cycle in CE_REL, nce unchanged.
- Simultaneous timeout set and new accept cannot occur, because accept only happens in IDLE.
- Timing counters are DATA-independent and width ceil(log2(max T)+1); a value of 0 is illegal.

Test Plan:
- Reset release: all outputs at reset values; op_ready=1; nwp follows ~wp_enable one cycle later.
- CMD 0x70 accept at cycle 0:
  - cycle 1: cle=1, nce=0, oe=1, data_out=0x0070.
  - cycles 2–3: nwe=0; cycles 4–5: nwe=1.
  - cycle 6: cle=0, op_ready=1.
- READ with nand_data_in=0xA5C3 during nre low: rd_valid single pulse, rd_data=0xA5C3 in the cycle nre rises; next op accepted 1+T_RP+T_REH cycles after accept.
- WAIT_RB with rnb low for 20 cycles then high: busy stays high; returns to IDLE 2–3 cycles after the rnb rise (plus T_WB); timeout=0.
- WAIT_RB with TO_W=4 and rnb held low: timeout=1 after T_WB+15 poll cycles; timeout stays set until the next accept, then clears.
- Back-to-back ADDR×5 then CE_OFF:
  - nce low continuously across all five ADDR ops; ale pulses per op.
  - nce=1 one cycle after CE_OFF accept.
  - Assert reset_n=0 mid-STROBE_LO: nwe=1 and nce=1 immediately.
